// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the TMR fault manager: replica FSM states and repair index encoding.
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    FM_OK      = 2'd0,
    FM_SUSPECT = 2'd1,
    FM_BROKEN  = 2'd2,
    FM_REPAIR  = 2'd3
  } fm_state_e;

  localparam int unsigned NUM_REPLICAS = 3;

  localparam logic [1:0] REPAIR_IDX_0 = 2'd0;
  localparam logic [1:0] REPAIR_IDX_1 = 2'd1;
  localparam logic [1:0] REPAIR_IDX_2 = 2'd2;

  // At most one replica is ever in repair, so a priority pick is exact.
  function automatic logic [1:0] fm_onehot_idx(input logic [NUM_REPLICAS-1:0] v);
    if (v[2]) return REPAIR_IDX_2;
    if (v[1]) return REPAIR_IDX_1;
    return REPAIR_IDX_0;
  endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// One replica's fault FSM with a saturating error counter.
//  state      | meaning
//  FM_OK      | no outstanding errors, cnt = 0
//  FM_SUSPECT | errors accumulating, 0 < cnt < THRESHOLD
//  FM_BROKEN  | threshold reached, replica excluded from voting
//  FM_REPAIR  | repair requested, waiting for ack
module cv32e40p_ft_err_counter
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned THRESHOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             grant,
  input  logic             ack,
  output logic [CNT_W-1:0] cnt,
  output logic             hit,
  output logic             broken,
  output logic             repair
);

  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 1);

  fm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             leak, eff_inc;

  // A leak tick coincident with an increment cancels it out.
  assign leak    = dec && (state_q == FM_SUSPECT);
  assign eff_inc = inc && !leak && ((state_q == FM_OK) || (state_q == FM_SUSPECT));
  assign hit     = eff_inc && (cnt_q == THR_M1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FM_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FM_OK, FM_SUSPECT: begin
        if (hit) begin
          if (grant) begin
            state_d = FM_BROKEN;
            cnt_d   = THR;
          end else begin
            cnt_d   = THR_M1;
            state_d = (THR_M1 == '0) ? FM_OK : FM_SUSPECT;
          end
        end else if (eff_inc) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = FM_SUSPECT;
        end else if (leak && !inc) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = FM_OK;
        end
      end
      FM_BROKEN: state_d = FM_REPAIR;
      FM_REPAIR: begin
        if (ack) begin
          state_d = FM_OK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FM_OK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cnt    = cnt_q;
    broken = (state_q == FM_BROKEN) || (state_q == FM_REPAIR);
    repair = (state_q == FM_REPAIR);
  end

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: per-replica error accounting, single-broken arbitration, repair handshake.
// Optional counter leak enabled by CV32E40P_FT_ERR_LEAK_EN.
module cv32e40p_tmr_fault_manager
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned THRESHOLD   = 8,
  parameter int unsigned LEAK_PERIOD = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_i,
  input  logic [NUM_REPLICAS-1:0]       block_err_i,
  input  logic                          err_detected_i,
  input  logic                          err_corrected_i,
  output logic [NUM_REPLICAS-1:0]       broken_block_o,
  output logic                          repair_req_o,
  output logic [1:0]                    repair_idx_o,
  input  logic                          repair_ack_i,
  output logic [NUM_REPLICAS*CNT_W-1:0] err_cnt_o,
  output logic                          fatal_o
);

  if (THRESHOLD < 1 || THRESHOLD > (2**CNT_W - 1)) begin : g_bad_threshold
    $error("THRESHOLD out of range for CNT_W");
  end
  if (LEAK_PERIOD < 2) begin : g_bad_leak
    $error("LEAK_PERIOD must be at least 2");
  end

  logic [NUM_REPLICAS-1:0] inc, hit, grant, broken, repair;
  logic                    uncorrectable, inc_en, busy, single_hit, fatal_q, leak_wrap;

  assign uncorrectable = valid_i && err_detected_i && !err_corrected_i;
  assign inc_en        = valid_i && !uncorrectable;
  assign inc           = inc_en ? block_err_i : '0;

  // Only one replica may be out of the vote; any refused promotion is fatal.
  assign busy       = |broken;
  assign single_hit = (hit != '0) && ((hit & (hit - 1'b1)) == '0);
  assign grant      = (!busy && single_hit) ? hit : '0;

`ifdef CV32E40P_FT_ERR_LEAK_EN
  localparam int unsigned LW = $clog2(LEAK_PERIOD);
  logic [LW-1:0] leak_q;

  always_ff @(posedge clk) begin
    if (!rst_n)            leak_q <= LW'(LEAK_PERIOD - 1);
    else if (leak_q == '0) leak_q <= LW'(LEAK_PERIOD - 1);
    else                   leak_q <= leak_q - 1'b1;
  end
  assign leak_wrap = (leak_q == '0);
`else
  assign leak_wrap = 1'b0;
`endif

  for (genvar k = 0; k < NUM_REPLICAS; k++) begin : g_rep
    cv32e40p_ft_err_counter #(
      .CNT_W    (CNT_W),
      .THRESHOLD(THRESHOLD)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[k]),
      .dec   (leak_wrap),
      .grant (grant[k]),
      .ack   (repair_ack_i),
      .cnt   (err_cnt_o[k*CNT_W +: CNT_W]),
      .hit   (hit[k]),
      .broken(broken[k]),
      .repair(repair[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fatal_q <= 1'b0;
    else        fatal_q <= fatal_q || uncorrectable || ((hit & ~grant) != '0);
  end

  assign broken_block_o = broken;
  assign repair_req_o   = |repair;
  assign repair_idx_o   = fm_onehot_idx(repair);
  assign fatal_o        = fatal_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Directed self-checking bench for cv32e40p_tmr_fault_manager (leak scenario under CV32E40P_FT_ERR_LEAK_EN).
module tb_cv32e40p_tmr_fault_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [2:0]  block_err;
  logic        err_detected;
  logic        err_corrected;
  logic [2:0]  broken_block;
  logic        repair_req;
  logic [1:0]  repair_idx;
  logic        repair_ack;
  logic [11:0] err_cnt;
  logic        fatal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40p_tmr_fault_manager #(
    .CNT_W      (4),
    .THRESHOLD  (8),
    .LEAK_PERIOD(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid),
    .block_err_i    (block_err),
    .err_detected_i (err_detected),
    .err_corrected_i(err_corrected),
    .broken_block_o (broken_block),
    .repair_req_o   (repair_req),
    .repair_idx_o   (repair_idx),
    .repair_ack_i   (repair_ack),
    .err_cnt_o      (err_cnt),
    .fatal_o        (fatal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt_of(input int k);
    return err_cnt[k*4 +: 4];
  endfunction

  task automatic step(input logic v, input logic [2:0] e, input logic det,
                      input logic cor, input logic ack);
    valid = v; block_err = e; err_detected = det; err_corrected = cor; repair_ack = ack;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle(1);
    chk({tag, "_broken"}, 32'(broken_block), 32'd0);
    chk({tag, "_req"},    32'(repair_req),   32'd0);
    chk({tag, "_idx"},    32'(repair_idx),   32'd0);
    chk({tag, "_cnt"},    32'(err_cnt),      32'd0);
    chk({tag, "_fatal"},  32'(fatal),        32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 0; block_err = 0; err_detected = 0; err_corrected = 0; repair_ack = 0;
    idle(2);
    do_reset("rst");

    // 1) eight errors on replica 1
    for (int i = 0; i < 7; i++) step(1'b1, 3'b010, 1'b1, 1'b1, 1'b0);
    chk("t1_cnt7",    32'(cnt_of(1)),   32'd7);
    chk("t1_nobrk7",  32'(broken_block), 32'd0);
    step(1'b1, 3'b010, 1'b1, 1'b1, 1'b0);
    chk("t1_cnt8",    32'(cnt_of(1)),   32'd8);
    chk("t1_broken",  32'(broken_block), 32'b010);
    chk("t1_noreq",   32'(repair_req),   32'd0);
    idle(1);
    chk("t1_req",     32'(repair_req),   32'd1);
    chk("t1_idx",     32'(repair_idx),   32'd1);
    chk("t1_fatal",   32'(fatal),        32'd0);

    // 2) ack after five waiting cycles; errors on replica 1 ignored meanwhile
    for (int i = 0; i < 5; i++) step(1'b1, 3'b010, 1'b1, 1'b1, 1'b0);
    chk("t2_reqhold", 32'(repair_req),   32'd1);
    chk("t2_cnthold", 32'(cnt_of(1)),   32'd8);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("t2_broken",  32'(broken_block), 32'd0);
    chk("t2_req",     32'(repair_req),   32'd0);
    chk("t2_cnt",     32'(cnt_of(1)),   32'd0);

    // valid=0 ignored, then multiple flags increment independently
    step(1'b0, 3'b111, 1'b1, 1'b1, 1'b0);
    chk("inv_cnt",    32'(err_cnt),      32'd0);
    step(1'b1, 3'b101, 1'b1, 1'b1, 1'b0);
    chk("multi_cnt",  32'(err_cnt),      32'h101);

    // 3) replica 0 to repair, then replica 2 blocked at THRESHOLD-1
    for (int i = 0; i < 7; i++) step(1'b1, 3'b001, 1'b1, 1'b1, 1'b0);
    chk("t3_brk0",    32'(broken_block), 32'b001);
    idle(1);
    chk("t3_idx0",    32'(repair_idx),   32'd0);
    chk("t3_req0",    32'(repair_req),   32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b101, 1'b1, 1'b1, 1'b0);
    chk("t3_cnt2_7",  32'(cnt_of(2)),   32'd7);
    chk("t3_nofatal", 32'(fatal),        32'd0);
    step(1'b1, 3'b101, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b101, 1'b1, 1'b1, 1'b0);
    chk("t3_cnt2sat", 32'(cnt_of(2)),   32'd7);
    chk("t3_fatal",   32'(fatal),        32'd1);
    chk("t3_brkonly0",32'(broken_block), 32'b001);
    chk("t3_cnt0",    32'(cnt_of(0)),   32'd8);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("t3_ack_cnt", 32'(err_cnt),      32'h700);
    chk("t3_ack_req", 32'(repair_req),   32'd0);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("late_ack",   32'(err_cnt),      32'h700);

    // 4) uncorrectable error
    do_reset("r4");
    step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("t4_fatal",   32'(fatal),        32'd1);
    chk("t4_cnt",     32'(err_cnt),      32'd0);
    idle(4);
    chk("t4_sticky",  32'(fatal),        32'd1);

    // two replicas cross threshold together
    do_reset("r_dual");
    for (int i = 0; i < 8; i++) step(1'b1, 3'b011, 1'b1, 1'b1, 1'b0);
    chk("dual_cnt",   32'(err_cnt),      32'h077);
    chk("dual_brk",   32'(broken_block), 32'd0);
    chk("dual_fatal", 32'(fatal),        32'd1);

    // 6) reset during repair
    do_reset("r6");
    for (int i = 0; i < 8; i++) step(1'b1, 3'b100, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("t6_req",     32'(repair_req),   32'd1);
    chk("t6_idx",     32'(repair_idx),   32'd2);
    do_reset("t6_rst");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("t6_lateack", 32'({broken_block, repair_req, err_cnt}), 32'd0);

    // 5) leak (or pure accumulation without it)
    do_reset("r5");
    for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 1'b1, 1'b1, 1'b0);
    idle(48);
`ifdef CV32E40P_FT_ERR_LEAK_EN
    chk("t5_leak",    32'(cnt_of(0)),   32'd0);
    step(1'b1, 3'b001, 1'b1, 1'b1, 1'b0);
    chk("t5_ok_again",32'(cnt_of(0)),   32'd1);
`else
    chk("t5_accum",   32'(cnt_of(0)),   32'd3);
`endif
    chk("t5_brk",     32'(broken_block), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
